// File: rtl/clint_timer.sv
// Machine-level core-local interruptor: 64-bit mtime/mtimecmp, msip, and the timer/software IRQ lines.
// Optional build macro CLINT_TIME_LATCH_EN adds a shadow of mtime[63:32] captured on mtime[31:0] reads.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              timer_irq_o,
    output logic              soft_irq_o
);

    localparam logic [ADDR_W-1:0] A_MSIP       = ADDR_W'(32'h0000);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_L = ADDR_W'(32'h4000);
    localparam logic [ADDR_W-1:0] A_MTIMECMP_H = ADDR_W'(32'h4004);
    localparam logic [ADDR_W-1:0] A_MTIME_L    = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] A_MTIME_H    = ADDR_W'(32'hBFFC);
    localparam logic [15:0]       TICK_LAST    = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] mtime_hi_rd;

    logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, hit;
    logic wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi, rd_time_lo;
    logic [31:0] rd_val;

    assign tick = (presc == TICK_LAST);

    // Misaligned offsets never select a register, so they fall through to the error path.
    always_comb begin
        sel_msip    = 1'b0;
        sel_cmp_lo  = 1'b0;
        sel_cmp_hi  = 1'b0;
        sel_time_lo = 1'b0;
        sel_time_hi = 1'b0;
        if (addr_i[1:0] == 2'b00) begin
            sel_msip    = (addr_i == A_MSIP);
            sel_cmp_lo  = (addr_i == A_MTIMECMP_L);
            sel_cmp_hi  = (addr_i == A_MTIMECMP_H);
            sel_time_lo = (addr_i == A_MTIME_L);
            sel_time_hi = (addr_i == A_MTIME_H);
        end
    end

    assign hit        = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
    assign wr_msip    = req_i & we_i & sel_msip;
    assign wr_cmp_lo  = req_i & we_i & sel_cmp_lo;
    assign wr_cmp_hi  = req_i & we_i & sel_cmp_hi;
    assign wr_time_lo = req_i & we_i & sel_time_lo;
    assign wr_time_hi = req_i & we_i & sel_time_hi;
    assign rd_time_lo = req_i & ~we_i & sel_time_lo;

`ifdef CLINT_TIME_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_hi_shadow <= '0;
        end else if (rd_time_lo) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    assign mtime_hi_rd = mtime_hi_shadow;
`else
    assign mtime_hi_rd = mtime[63:32];
`endif

    always_comb begin
        rd_val = '0;
        if (sel_msip)    rd_val = {31'd0, msip};
        if (sel_cmp_lo)  rd_val = mtimecmp[31:0];
        if (sel_cmp_hi)  rd_val = mtimecmp[63:32];
        if (sel_time_lo) rd_val = mtime[31:0];
        if (sel_time_hi) rd_val = mtime_hi_rd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc       <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            timer_irq_o <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;

            // A write to either half wins over the tick; no carry crosses halves on a write.
            if (wr_time_lo) begin
                mtime[31:0] <= wdata_i;
            end else if (wr_time_hi) begin
                mtime[63:32] <= wdata_i;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_cmp_lo) mtimecmp[31:0]  <= wdata_i;
            if (wr_cmp_hi) mtimecmp[63:32] <= wdata_i;
            if (wr_msip)   msip            <= wdata_i[0];

            rvalid_o    <= req_i;
            rdata_o     <= (req_i && !we_i && hit) ? rd_val : 32'd0;
            err_o       <= req_i & ~hit;
            timer_irq_o <= (mtime >= mtimecmp);
        end
    end

    assign soft_irq_o = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance at TICK_DIV=1, a second at TICK_DIV=4 sharing the bus.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        rvalid, err, timer_irq, soft_irq;
    logic [31:0] rdata;
    logic        rvalid4, err4, timer_irq4, soft_irq4;
    logic [31:0] rdata4;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned edge_cnt = 0;

`ifdef CLINT_TIME_LATCH_EN
    localparam logic [31:0] EXP_STRADDLE_HI = 32'd0;
`else
    localparam logic [31:0] EXP_STRADDLE_HI = 32'd1;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .timer_irq_o(timer_irq), .soft_irq_o(soft_irq)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4),
        .timer_irq_o(timer_irq4), .soft_irq_o(soft_irq4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access; on return the response for it is visible.
    task automatic bus(input bit wr, input logic [15:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = wr;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        int n;

        // 1: reset, then 10 idle cycles at TICK_DIV=1
        cyc(2);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_timer_irq", timer_irq, 1'b0);
        chk("rst_soft_irq", soft_irq, 1'b0);
        rst = 1'b0;
        cyc(10);
        bus(0, 16'hBFF8, 0);
        chk("t1_rvalid", rvalid, 1'b1);
        chk("t1_mtime_lo", rdata, 32'd10);
        chk("t1_err", err, 1'b0);
        chk("t1_timer_irq", timer_irq, 1'b0);
        chk("t1_soft_irq", soft_irq, 1'b0);
        bus(0, 16'h4000, 0);
        chk("t1_cmp_lo_rst", rdata, 32'hFFFF_FFFF);

        // 2: compare at 20
        bus(1, 16'h4004, 32'd0);
        chk("t2_wr_rdata", rdata, 32'd0);
        bus(1, 16'hBFF8, 32'd0);
        bus(1, 16'h4000, 32'd20);
        cyc(19);
        chk("t2_irq_before", timer_irq, 1'b0);
        cyc(1);
        chk("t2_irq_rise", timer_irq, 1'b1);
        bus(1, 16'h4000, 32'hFFFF_FFFF);
        chk("t2_irq_hold", timer_irq, 1'b1);
        cyc(1);
        chk("t2_irq_fall", timer_irq, 1'b0);

        // 3: software interrupt
        bus(1, 16'h0000, 32'h3);
        chk("t3_soft_set", soft_irq, 1'b1);
        bus(0, 16'h0000, 0);
        chk("t3_msip_rd", rdata, 32'h1);
        bus(1, 16'h0000, 32'h0);
        chk("t3_soft_clr", soft_irq, 1'b0);

        // 4: lo wrap into hi
        bus(1, 16'hBFF8, 32'hFFFF_FFFE);
        bus(1, 16'hBFFC, 32'd0);
        cyc(3);
        bus(0, 16'hBFF8, 0);
        chk("t4_lo_after_wrap", rdata, 32'd1);
        bus(0, 16'hBFFC, 0);
        chk("t4_hi_after_wrap", rdata, 32'd1);
        bus(1, 16'hBFF8, 32'hFFFF_FFFF);
        bus(1, 16'hBFFC, 32'd0);
        bus(0, 16'hBFF8, 0);
        chk("t4_straddle_lo", rdata, 32'hFFFF_FFFF);
        bus(0, 16'hBFFC, 0);
        chk("t4_straddle_hi", rdata, EXP_STRADDLE_HI);

        // 5: TICK_DIV=4, mtime write coinciding with a tick
        bus(1, 16'hBFF8, 32'd0);
        bus(1, 16'hBFFC, 32'd0);
        n = 0;
        while (((edge_cnt + 1) % 4) != 0 && n < 8) begin
            cyc(1);
            n++;
        end
        chk("t5_align", ((edge_cnt + 1) % 4), 0);
        bus(1, 16'hBFF8, 32'd0);
        bus(0, 16'hBFF8, 0);
        chk("t5_after_wr", rdata4, 32'd0);
        cyc(2);
        bus(0, 16'hBFF8, 0);
        chk("t5_before_inc", rdata4, 32'd0);
        bus(0, 16'hBFF8, 0);
        chk("t5_inc", rdata4, 32'd1);

        // 6: error responses and back-to-back reads
        bus(0, 16'h0008, 0);
        chk("t6_err_0008", err, 1'b1);
        chk("t6_rd_0008", rdata, 32'd0);
        bus(0, 16'h4002, 0);
        chk("t6_err_4002", err, 1'b1);
        chk("t6_rd_4002", rdata, 32'd0);
        bus(1, 16'h0001, 32'h1);
        chk("t6_err_mis_wr", err, 1'b1);
        chk("t6_soft_unchanged", soft_irq, 1'b0);
        bus(1, 16'h4006, 32'h0);
        bus(0, 16'h4004, 0);
        chk("t6_ok_err", err, 1'b0);
        chk("t6_cmp_hi_kept", rdata, 32'd0);
        req = 1'b1; we = 1'b0; addr = 16'h0000;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) n++;
        end
        req = 1'b0;
        chk("t6_b2b_count", n, 5);
        cyc(1);
        chk("t6_b2b_end", rvalid, 1'b0);

        // reset during an access drops its response and its write
        req = 1'b1; we = 1'b1; addr = 16'h0000; wdata = 32'h1;
        rst = 1'b1;
        cyc(1);
        req = 1'b0; we = 1'b0;
        chk("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_soft", soft_irq, 1'b0);
        rst = 1'b0;
        bus(0, 16'hBFF8, 0);
        chk("rst_mid_mtime", rdata, 32'd0);
        bus(0, 16'h4004, 0);
        chk("rst_mid_cmp_hi", rdata, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
